bht_update_ctrl: RTL
====================

// Module: bht_update_ctrl
// PURPOSE
//  Resolution-side partner of the bimodal BHT: tracks in-flight predictions (index + predicted
//  direction) in order, pairs each with its branch outcome from execute, and drives the BHT
//  write-back (update enable, index, actual direction). Sits between fetch/predict and execute.
//  Also flags mispredictions and compiles in optional accuracy counters.
// PARAMETERS
//  IDX_W   `BHT_IDX_WIDTH (common_defines.svh)  BHT index width
//  DEPTH   8                                    in-flight entries; power of two, >=2
//  CNT_W   16                                   statistics counter width
// PORTS
//  clk_i            in   1          clock, all state on rising edge
//  rst_ni           in   1          asynchronous, active-low reset
//  pred_valid_i     in   1          prediction issued this cycle
//  pred_ready_o     out  1          queue can accept a prediction
//  pred_idx_i       in   IDX_W      BHT index used for the prediction
//  pred_taken_i     in   1          predicted direction
//  res_valid_i      in   1          oldest in-flight branch resolved this cycle
//  res_taken_i      in   1          actual direction
//  flush_i          in   1          discard all in-flight entries
//  upd_en_o         out  1          BHT update strobe (1-cycle pulse)
//  upd_idx_o        out  IDX_W      index to update
//  upd_taken_o      out  1          actual outcome to train with
//  mispredict_o     out  1          1-cycle pulse, aligned with upd_en_o, predicted != actual
//  res_err_o        out  1          1-cycle pulse: resolution arrived with queue empty
//  occupancy_o      out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  - Reset (rst_ni=0, async): queue empty, pointers 0, pred_ready_o=1, upd_en_o=0,
//    upd_idx_o=0, upd_taken_o=0, mispredict_o=0, res_err_o=0, occupancy_o=0, counters 0.
//    Reset mid-operation drops all entries; no update issued for them.
//  - Storage: circular FIFO, rd/wr pointers of $clog2(DEPTH)+1 bits (MSB = wrap bit);
//    full when low bits equal and MSBs differ; empty when pointers equal.
//  - pred_ready_o = !full, combinational from registered pointers only (no same-cycle bypass):
//    when full, push refused even if a pop occurs that cycle.
//  - Push: pred_valid_i & pred_ready_o & !flush_i writes {pred_idx_i,pred_taken_i} at wr ptr.
//  - Pop: res_valid_i & !empty reads head; next cycle upd_en_o=1, upd_idx_o=head idx,
//    upd_taken_o=res_taken_i, mispredict_o=(head taken != res_taken_i). Latency 1 cycle.
//  - res_valid_i while empty (incl. same cycle as a push into empty queue): no pop, no update,
//    res_err_o=1 next cycle. A push never bypasses to a same-cycle resolution.
//  - Simultaneous push+pop (not full, not empty): both occur, occupancy unchanged.
//  - flush_i: a same-cycle valid pop is still processed (update issued next cycle); all other
//    entries discarded, pointers set equal (wr ptr := rd ptr after pop); same-cycle push dropped.
//  - upd_idx_o/upd_taken_o hold last value when upd_en_o=0.
//  - Pointer wrap-around at DEPTH is natural binary overflow of the extended pointers.
// CONFIGURATION
//  BHT_UPD_STATS_EN defined: extra outputs resolved_cnt_o and mispred_cnt_o (CNT_W each, out);
//    resolved_cnt_o += 1 per upd_en_o pulse, mispred_cnt_o += 1 per mispredict_o pulse;
//    both saturate at all-ones (no wrap); cleared only by reset, not by flush_i.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: hold rst_ni=0 with random inputs -> all outputs 0, pred_ready_o=1, occupancy_o=0.
//  2 Push idx 5 taken=1, then res taken=1 -> next cycle upd_en_o=1, upd_idx_o=5,
//    upd_taken_o=1, mispredict_o=0; push idx 9 taken=0, res taken=1 -> mispredict_o=1.
//  3 Fill 8 entries -> pred_ready_o=0, occupancy_o=8; push+res same cycle -> push refused,
//    occupancy_o=7; drain all 8 -> updates in original push order, idx matching.
//  4 Queue of 3, assert flush_i with res_valid_i -> exactly one update (oldest), occupancy_o=0.
//  5 Empty queue, res_valid_i with pred_valid_i -> res_err_o=1, no upd_en_o, occupancy_o=1.
//  6 BHT_UPD_STATS_EN, CNT_W=2: 5 mispredicted resolutions -> mispred_cnt_o=3 (saturated),
//    resolved_cnt_o=3; assert rst_ni=0 mid-drain -> counters and occupancy 0 asynchronously.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl
//   Resolution-side partner of the bimodal BHT. Keeps in-flight predictions (index + predicted
//   direction) in program order. It pairs each prediction with its branch outcome from
//   execute and drives the BHT write-back port one cycle after the resolution.
//
//   Optional feature macro: BHT_UPD_STATS_EN. When it is defined, the resolved and
//   mispredicted counters and their output ports are compiled in. Both counters saturate.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pred_valid_i/ready_o   prediction handshake; pred_idx_i, pred_taken_i are the payload
//   res_valid_i/taken_i    oldest in-flight branch resolved, with its actual direction
//   flush_i                discard in-flight entries (a same-cycle pop still completes)
//   upd_en_o/idx_o/taken_o BHT write-back; idx/taken hold when upd_en_o is low
//   mispredict_o           pulse aligned with upd_en_o when predicted != actual
//   res_err_o              pulse when a resolution arrived with the queue empty
//   occupancy_o            entries currently held
//   resolved_cnt_o, mispred_cnt_o   (BHT_UPD_STATS_EN only) saturating statistics

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 10
`endif

module bht_update_ctrl #(
    parameter int unsigned IDX_W = `BHT_IDX_WIDTH,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [IDX_W-1:0]         pred_idx_i,
    input  logic                     pred_taken_i,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic                     flush_i,
    output logic                     upd_en_o,
    output logic [IDX_W-1:0]         upd_idx_o,
    output logic                     upd_taken_o,
    output logic                     mispredict_o,
    output logic                     res_err_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef BHT_UPD_STATS_EN
    ,
    output logic [CNT_W-1:0]         resolved_cnt_o,
    output logic [CNT_W-1:0]         mispred_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned AW    = PTR_W - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("bht_update_ctrl: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    // Extended pointers: the MSB is the wrap bit.
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [IDX_W-1:0] r_mem_idx   [DEPTH];
    logic             r_mem_taken [DEPTH];

    logic             w_full, w_empty, w_push, w_pop;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;

    logic             r_upd_en, r_upd_taken, r_mispredict, r_res_err;
    logic [IDX_W-1:0] r_upd_idx;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Ready looks only at registered pointers, so a full queue refuses a push even when a
    // pop frees a slot in the same cycle.
    assign pred_ready_o = !w_full;
    assign w_push       = pred_valid_i && !w_full && !flush_i;
    assign w_pop        = res_valid_i && !w_empty;

    assign w_head_idx   = r_mem_idx[r_rd_ptr[AW-1:0]];
    assign w_head_taken = r_mem_taken[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_rd_ptr_d = r_rd_ptr + (w_pop ? PTR_W'(1) : PTR_W'(0));
        if (flush_i) begin
            w_wr_ptr_d = w_rd_ptr_d;  // flush empties the queue after any same-cycle pop
        end else begin
            w_wr_ptr_d = r_wr_ptr + (w_push ? PTR_W'(1) : PTR_W'(0));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_idx[r_wr_ptr[AW-1:0]]   <= pred_idx_i;
            r_mem_taken[r_wr_ptr[AW-1:0]] <= pred_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_upd_en     <= 1'b0;
            r_upd_idx    <= '0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
            r_res_err    <= 1'b0;
        end else begin
            r_upd_en     <= w_pop;
            r_mispredict <= w_pop && (w_head_taken != res_taken_i);
            r_res_err    <= res_valid_i && w_empty;
            if (w_pop) begin
                r_upd_idx   <= w_head_idx;
                r_upd_taken <= res_taken_i;
            end
        end
    end

    assign upd_en_o     = r_upd_en;
    assign upd_idx_o    = r_upd_idx;
    assign upd_taken_o  = r_upd_taken;
    assign mispredict_o = r_mispredict;
    assign res_err_o    = r_res_err;
    assign occupancy_o  = r_wr_ptr - r_rd_ptr;

`ifdef BHT_UPD_STATS_EN
    logic [CNT_W-1:0] r_resolved_cnt, r_mispred_cnt;

    // Counters are cleared only by reset; flush leaves them untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resolved_cnt <= '0;
            r_mispred_cnt  <= '0;
        end else begin
            if (r_upd_en && (r_resolved_cnt != '1)) begin
                r_resolved_cnt <= r_resolved_cnt + CNT_W'(1);
            end
            if (r_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign resolved_cnt_o = r_resolved_cnt;
    assign mispred_cnt_o  = r_mispred_cnt;
`else
    // Statistics not built: no counters, no ports.
`endif

endmodule
